// File: rtl/sc_pkg.sv
// Shared stochastic-compute definitions: default precision/lane count (common
// with FSM_MUX), window length and the sn_counter state encoding.
package sc_pkg;

  localparam int SC_NUM_BIT = 8;
  localparam int SC_DIM     = 4;
  localparam int WIN_LEN    = 2 ** SC_NUM_BIT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } sn_cnt_state_t;

endpackage

// File: rtl/sn_counter_lane_cnt.sv
// One lane's ones counter: cleared at window start, advances by the lane bit
// on each qualified sample, holds otherwise.
module sn_lane_cnt #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic         lane_bit,
  output logic [W-1:0] count
);

  // Lane ones-count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (clear) begin
      count <= {W{1'b0}};
    end else if (enable) begin
      count <= count + {{(W-1){1'b0}}, lane_bit};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/sn_counter.sv
// Stochastic-to-binary converter: counts ones per lane over 2^NUM_BIT valid
// samples. Define SN_CNT_BIPOLAR_EN to emit bipolar (2*count - 2^NUM_BIT) results.
module sn_counter
  import sc_pkg::*;
#(
  parameter int NUM_BIT = SC_NUM_BIT,
  parameter int DIM     = SC_DIM
) (
  input  logic                        i_clk_sn_cnt,
  input  logic                        i_rst_sn_cnt,
  input  logic                        i_start_sn_cnt,
  input  logic                        i_stop_sn_cnt,
  input  logic                        i_isgen,
  input  logic [DIM-1:0]              i_sn_bit,
  output logic [DIM-1:0][NUM_BIT:0]   o_bn,
  output logic                        o_valid_sn_cnt,
  output logic                        o_busy_sn_cnt
);

  localparam logic [NUM_BIT:0] WIN_CNT = {1'b1, {NUM_BIT{1'b0}}};
  localparam logic [NUM_BIT:0] ONE     = {{NUM_BIT{1'b0}}, 1'b1};

  sn_cnt_state_t             state_r;
  logic [NUM_BIT:0]          sample_cnt_r;
  logic [NUM_BIT:0]          sample_next_s;
  logic [DIM-1:0][NUM_BIT:0] lane_cnt_s;
  logic [DIM-1:0][NUM_BIT:0] lane_final_s;
  logic [DIM-1:0][NUM_BIT:0] bn_load_s;
  logic                      lane_clear_s;
  logic                      lane_enable_s;
  logic                      last_sample_s;

  // Start clears lanes in every state; harmless outside COUNT and required on restart.
  assign lane_clear_s  = i_start_sn_cnt;
  assign lane_enable_s = (state_r == COUNT) && i_isgen;
  assign sample_next_s = sample_cnt_r + ONE;
  assign last_sample_s = lane_enable_s && !i_start_sn_cnt && !i_stop_sn_cnt
                         && (sample_next_s == WIN_CNT);

  generate
    for (genvar k = 0; k < DIM; k++) begin : g_lane
      sn_lane_cnt #(
        .W(NUM_BIT + 1)
      ) u_lane (
        .clk      (i_clk_sn_cnt),
        .rst      (i_rst_sn_cnt),
        .clear    (lane_clear_s),
        .enable   (lane_enable_s),
        .lane_bit (i_sn_bit[k]),
        .count    (lane_cnt_s[k])
      );
    end
  endgenerate

  // Result mapping, folding in the final sample that is still on the inputs
  always_comb begin
    lane_final_s = {(DIM * (NUM_BIT + 1)){1'b0}};
    bn_load_s    = {(DIM * (NUM_BIT + 1)){1'b0}};
    for (int k = 0; k < DIM; k++) begin
      lane_final_s[k] = lane_cnt_s[k] + {{NUM_BIT{1'b0}}, i_sn_bit[k]};
`ifdef SN_CNT_BIPOLAR_EN
      bn_load_s[k] = {lane_final_s[k][NUM_BIT-1:0], 1'b0} - WIN_CNT;
`else
      bn_load_s[k] = lane_final_s[k];
`endif
    end
  end

  // Window FSM, sample counter and registered outputs
  always_ff @(posedge i_clk_sn_cnt) begin
    if (i_rst_sn_cnt) begin
      state_r        <= IDLE;
      sample_cnt_r   <= {(NUM_BIT + 1){1'b0}};
      o_bn           <= {(DIM * (NUM_BIT + 1)){1'b0}};
      o_valid_sn_cnt <= 1'b0;
      o_busy_sn_cnt  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          o_valid_sn_cnt <= 1'b0;
          if (i_start_sn_cnt) begin
            sample_cnt_r  <= {(NUM_BIT + 1){1'b0}};
            state_r       <= COUNT;
            o_busy_sn_cnt <= 1'b1;
          end else begin
            o_busy_sn_cnt <= 1'b0;
          end
        end
        COUNT: begin
          o_valid_sn_cnt <= 1'b0;
          if (i_start_sn_cnt) begin
            sample_cnt_r  <= {(NUM_BIT + 1){1'b0}};
            o_busy_sn_cnt <= 1'b1;
          end else if (i_stop_sn_cnt) begin
            state_r       <= IDLE;
            o_busy_sn_cnt <= 1'b0;
          end else if (last_sample_s) begin
            sample_cnt_r   <= sample_next_s;
            o_bn           <= bn_load_s;
            o_valid_sn_cnt <= 1'b1;
            o_busy_sn_cnt  <= 1'b0;
            state_r        <= DONE;
          end else if (i_isgen) begin
            sample_cnt_r <= sample_next_s;
          end else begin
            sample_cnt_r <= sample_cnt_r;
          end
        end
        DONE: begin
          o_valid_sn_cnt <= 1'b0;
          if (i_start_sn_cnt) begin
            sample_cnt_r  <= {(NUM_BIT + 1){1'b0}};
            state_r       <= COUNT;
            o_busy_sn_cnt <= 1'b1;
          end else begin
            state_r       <= IDLE;
            o_busy_sn_cnt <= 1'b0;
          end
        end
        default: begin
          state_r        <= IDLE;
          o_valid_sn_cnt <= 1'b0;
          o_busy_sn_cnt  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sn_counter.sv
// Scoreboard bench for sn_counter (NUM_BIT=8, DIM=4): directed windows push
// expected results; a negedge monitor checks every valid strobe.
module tb_sn_counter;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            stop;
  logic            isgen;
  logic [3:0]      sn_bit;
  logic [3:0][8:0] bn;
  logic            valid;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int              at;
    logic [3:0][8:0] bn;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  sn_counter #(.NUM_BIT(8), .DIM(4)) dut (
    .i_clk_sn_cnt   (clk),
    .i_rst_sn_cnt   (rst),
    .i_start_sn_cnt (start),
    .i_stop_sn_cnt  (stop),
    .i_isgen        (isgen),
    .i_sn_bit       (sn_bit),
    .o_bn           (bn),
    .o_valid_sn_cnt (valid),
    .o_busy_sn_cnt  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [8:0] exp_bn(input int c);
`ifdef SN_CNT_BIPOLAR_EN
    exp_bn = 9'(2 * c - 256);
`else
    exp_bn = 9'(c);
`endif
  endfunction

  function automatic logic [3:0] pat(input int mode, input int idx);
    logic [3:0] b;
    b = 4'h0;
    case (mode)
      0: b = 4'hF;
      1: for (int k = 0; k < 4; k++) b[k] = ((idx % (k + 1)) == 0);
      default: b = ((idx % 2) == 0) ? 4'hF : 4'h0;
    endcase
    return b;
  endfunction

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("strobe_cycle", cyc, mon_e.at);
        for (int k = 0; k < 4; k++) chk("o_bn_lane", int'(bn[k]), int'(mon_e.bn[k]));
      end
    end
  end

  task automatic step(input logic s, input logic p, input logic g, input logic [3:0] b);
    start = s; stop = p; isgen = g; sn_bit = b;
    @(posedge clk);
    #1;
  endtask

  // Full window: start (optionally with stop), 256 samples, optional bubble run
  task automatic run_window(input int mode, input int bub_at, input int bub_len,
                            input int c0, input int c1, input int c2, input int c3,
                            input logic with_stop);
    exp_t e;
    e.at    = cyc + 1 + 256 + bub_len;
    e.bn[0] = exp_bn(c0);
    e.bn[1] = exp_bn(c1);
    e.bn[2] = exp_bn(c2);
    e.bn[3] = exp_bn(c3);
    sb.push_back(e);
    step(1'b1, with_stop, 1'b1, 4'hF);
    chk("busy_after_start", int'(busy), 1);
    for (int idx = 0; idx < 256; idx++) begin
      if (idx == bub_at) repeat (bub_len) step(1'b0, 1'b0, 1'b0, 4'hF);
      step(1'b0, 1'b0, 1'b1, pat(mode, idx));
    end
    step(1'b0, 1'b0, 1'b0, 4'h0);
    chk("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; isgen = 1'b0; sn_bit = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) chk("reset_o_bn", int'(bn[k]), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_busy", int'(busy), 0);
    step(1'b0, 1'b0, 1'b1, 4'hF);

    // All-ones, every-(k+1), alternating with a 10-cycle bubble at sample 100
    run_window(0, -1, 0, 256, 256, 256, 256, 1'b0);
    run_window(1, -1, 0, 256, 128, 86, 64, 1'b0);
    run_window(2, 100, 10, 128, 128, 128, 128, 1'b0);

    // Abort at sample 100: no strobe, previous result held
    step(1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, 4'hF);
    step(1'b0, 1'b1, 1'b1, 4'hF);
    chk("busy_after_stop", int'(busy), 0);
    for (int k = 0; k < 4; k++) chk("held_o_bn", int'(bn[k]), int'(exp_bn(128)));
    repeat (300) step(1'b0, 1'b0, 1'b1, 4'hF);
    run_window(0, -1, 0, 256, 256, 256, 256, 1'b0);

    // Restart at sample 50, plain and with stop asserted alongside
    step(1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b1, 4'hF);
    run_window(2, -1, 0, 128, 128, 128, 128, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b1, 4'hF);
    run_window(1, -1, 0, 256, 128, 86, 64, 1'b1);

    // Reset mid-window
    step(1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, 4'hF);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'hF);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) chk("midreset_o_bn", int'(bn[k]), 0);
    chk("midreset_valid", int'(valid), 0);
    chk("midreset_busy", int'(busy), 0);
    repeat (300) step(1'b0, 1'b0, 1'b1, 4'hF);
    run_window(2, -1, 0, 128, 128, 128, 128, 1'b0);

    repeat (3) step(1'b0, 1'b0, 1'b0, 4'h0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
